// File: rtl/awg_sample_if.sv
// PS-GPIO command handshake plus the BRAM write-port signals of the AWG sample loader.
// master = PS/bench side, slave = loader side.
interface awg_sample_if #(
  parameter int RAM_DEPTH       = 15,
  parameter int GPIO_DATA_WIDTH = 16
);
  logic                       gpio_strobe;
  logic [1:0]                 gpio_cmd;
  logic [GPIO_DATA_WIDTH-1:0] gpio_data;
  logic                       gpio_ack;
  logic [1:0]                 we;
  logic [RAM_DEPTH-1:0]       row;
  logic [2:0]                 col;
  logic [GPIO_DATA_WIDTH-1:0] gpio_data_out;
  logic [31:0]                max_points;
  logic                       busy;
  logic                       err;

  modport master (
    output gpio_strobe, gpio_cmd, gpio_data,
    input  gpio_ack, we, row, col, gpio_data_out, max_points, busy, err
  );

  modport slave (
    input  gpio_strobe, gpio_cmd, gpio_data,
    output gpio_ack, we, row, col, gpio_data_out, max_points, busy, err
  );
endinterface

// File: rtl/awg_sample_loader.sv
// Loads PS samples into the two-bank AWG sample BRAM in time order, pads the last row
// pair with zeros on COMMIT and publishes the new MAX_POINTS. Single clock domain (wclk).
module awg_sample_loader #(
  parameter int          RAM_DEPTH       = 15,
  parameter int          GPIO_DATA_WIDTH = 16,
  parameter logic [31:0] DEFAULT_MAX     = 32'd0
) (
  input  logic        wclk,
  input  logic        wresetn,
  awg_sample_if.slave bus
);

  localparam int S_W = RAM_DEPTH + 5;
  localparam logic [S_W-1:0] CAP   = {1'b1, {(RAM_DEPTH + 4){1'b0}}};
  localparam logic [S_W-1:0] S_ONE = {{(S_W - 1){1'b0}}, 1'b1};

  localparam logic [1:0] CMD_START  = 2'd0;
  localparam logic [1:0] CMD_DATA   = 2'd1;
  localparam logic [1:0] CMD_COMMIT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAD,
    ST_COMMIT
  } state_e;

  state_e state_q, state_d;

  (* ASYNC_REG = "TRUE" *) logic sync1_q;
  (* ASYNC_REG = "TRUE" *) logic sync2_q;
  logic sync1_d, sync2_d;
  logic sync3_q, sync3_d;

  logic [S_W-1:0]             s_q, s_d;
  logic [1:0]                 we_q, we_d;
  logic [RAM_DEPTH-1:0]       row_q, row_d;
  logic [2:0]                 col_q, col_d;
  logic [GPIO_DATA_WIDTH-1:0] data_q, data_d;
  logic [31:0]                max_q, max_d;
  logic                       ack_q, ack_d;
  logic                       err_q, err_d;

  logic           evt;
  logic [S_W-1:0] s_dec;

  always_ff @(posedge wclk or negedge wresetn) begin
    if (!wresetn) begin
      state_q <= ST_IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      s_q     <= '0;
      we_q    <= 2'd0;
      row_q   <= '0;
      col_q   <= 3'd0;
      data_q  <= '0;
      max_q   <= DEFAULT_MAX;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      s_q     <= s_d;
      we_q    <= we_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      max_q   <= max_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // we is registered with the row/col/data triple so a bank switch never pairs with a stale index.
  // sync3 only advances in IDLE/LOAD, which keeps an event raised in PAD/COMMIT pending.
  always_comb begin
    state_d = state_q;
    sync1_d = bus.gpio_strobe;
    sync2_d = sync1_q;
    sync3_d = sync3_q;
    s_d     = s_q;
    we_d    = we_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    max_d   = max_q;
    ack_d   = ack_q;
    err_d   = err_q;
    evt     = sync2_q ^ sync3_q;
    s_dec   = s_q - S_ONE;

    unique case (state_q)
      ST_IDLE: begin
        we_d = 2'd0;
        if (evt) begin
          sync3_d = sync2_q;
          ack_d   = ~ack_q;
          if (bus.gpio_cmd == CMD_START) begin
            s_d     = '0;
            err_d   = 1'b0;
            we_d    = 2'd1;
            state_d = ST_LOAD;
          end else if (bus.gpio_cmd == CMD_DATA) begin
            err_d = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (evt) begin
          sync3_d = sync2_q;
          ack_d   = ~ack_q;
          if (bus.gpio_cmd == CMD_START) begin
            s_d   = '0;
            err_d = 1'b0;
            we_d  = 2'd1;
          end else if (bus.gpio_cmd == CMD_DATA) begin
            if (s_q == CAP) begin
              err_d = 1'b1;
            end else begin
              row_d  = s_q[RAM_DEPTH+3:4];
              col_d  = s_q[2:0];
              data_d = bus.gpio_data;
              we_d   = s_q[3] ? 2'd2 : 2'd1;
              s_d    = s_q + S_ONE;
            end
          end else if (bus.gpio_cmd == CMD_COMMIT) begin
            if (s_q == '0) begin
              err_d   = 1'b1;
              we_d    = 2'd0;
              state_d = ST_IDLE;
            end else begin
              // ack is deferred to the COMMIT state edge
              ack_d   = ack_q;
              state_d = (s_q[3:0] != 4'd0) ? ST_PAD : ST_COMMIT;
            end
          end
        end
      end

      ST_PAD: begin
        row_d  = s_q[RAM_DEPTH+3:4];
        col_d  = s_q[2:0];
        data_d = '0;
        we_d   = s_q[3] ? 2'd2 : 2'd1;
        s_d    = s_q + S_ONE;
        if (s_q[3:0] == 4'hF) begin
          state_d = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        max_d   = 32'(s_dec >> 4);
        we_d    = 2'd0;
        ack_d   = ~ack_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.gpio_ack      = ack_q;
  assign bus.we            = we_q;
  assign bus.row           = row_q;
  assign bus.col           = col_q;
  assign bus.gpio_data_out = data_q;
  assign bus.max_points    = max_q;
  assign bus.busy          = (state_q == ST_PAD) || (state_q == ST_COMMIT);
  assign bus.err           = err_q;

endmodule
